// File: rtl/shift24_tx_ctrl.sv
// Serial transmit controller for an external 24-bit shift register: captures a word,
// pulses Load, steps Shift_En once per bit period, then idles for a fixed gap.
module shift24_tx_ctrl #(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_Valid,
  input  logic [23:0] In_Data,
  output logic        In_Ready,
  input  logic        Abort,
  output logic        Reg_Load,
  output logic [23:0] Reg_D,
  output logic        Reg_Shift_En,
  output logic        Ser_Valid,
  output logic        Busy,
  output logic        Done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      bidx, bidx_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            done_n, shen_n, accept;

  assign In_Ready = (state == IDLE) && !Abort;
  assign accept   = In_Valid && In_Ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    gcnt_n  = gcnt;
    done_n  = 1'b0;
    case (state)
      IDLE:  if (accept) state_n = LOAD;
      LOAD: begin
        state_n = SHIFT;
        cnt_n   = '0;
        bidx_n  = '0;
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bidx == 5'd23) begin
            gcnt_n = '0;
            if (GAP_CYCLES == 0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = GAP;
            end
          end else begin
            bidx_n = bidx + 5'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides everything mid-frame and suppresses the Done pulse
    if (Abort && state != IDLE) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
    // Shift only on the last cycle of bits 0..22; bit 23 is already at Shift_Out
    shen_n = (state_n == SHIFT) && (cnt_n == CNT_LAST) && (bidx_n != 5'd23);
  end

  // Outputs are registered from the next-state decode so they line up with state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bidx         <= '0;
      gcnt         <= '0;
      Reg_D        <= '0;
      Reg_Load     <= 1'b0;
      Reg_Shift_En <= 1'b0;
      Ser_Valid    <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bidx         <= bidx_n;
      gcnt         <= gcnt_n;
      Reg_Load     <= (state_n == LOAD);
      Reg_Shift_En <= shen_n;
      Ser_Valid    <= (state_n == SHIFT);
      Busy         <= (state_n != IDLE);
      Done         <= done_n;
      if (accept) Reg_D <= In_Data;
    end
  end

endmodule

// File: tb/tb_shift24_tx_ctrl.sv
// Directed bench: default instance plus a BIT_CYCLES=1/GAP_CYCLES=0 instance, with a
// model of the attached shift register rebuilding the serial stream.
module tb_shift24_tx_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic v0, ab0, rdy0, ld0, sh0, sv0, bz0, dn0;
  logic v1, ab1, rdy1, ld1, sh1, sv1, bz1, dn1;
  logic [23:0] d0, rd0, d1, rd1;

  shift24_tx_ctrl dut0 (
    .Clk(Clk), .Reset(Reset), .In_Valid(v0), .In_Data(d0), .In_Ready(rdy0),
    .Abort(ab0), .Reg_Load(ld0), .Reg_D(rd0), .Reg_Shift_En(sh0),
    .Ser_Valid(sv0), .Busy(bz0), .Done(dn0)
  );

  shift24_tx_ctrl #(.BIT_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .In_Valid(v1), .In_Data(d1), .In_Ready(rdy1),
    .Abort(ab1), .Reg_Load(ld1), .Reg_D(rd1), .Reg_Shift_En(sh1),
    .Ser_Valid(sv1), .Busy(bz1), .Done(dn1)
  );

  // observed instance selected by sel
  logic sel = 1'b0;
  logic m_ld, m_sh, m_sv, m_bz, m_dn, m_rdy;
  logic [23:0] m_d;
  assign m_ld  = sel ? ld1  : ld0;
  assign m_sh  = sel ? sh1  : sh0;
  assign m_sv  = sel ? sv1  : sv0;
  assign m_bz  = sel ? bz1  : bz0;
  assign m_dn  = sel ? dn1  : dn0;
  assign m_rdy = sel ? rdy1 : rdy0;
  assign m_d   = sel ? rd1  : rd0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  int cyc, load_cnt, load_cyc, sv_first, sv_last, sv_cnt, sh_cnt, sh_first, sh_last;
  int done_cnt, done_cyc, first_done_cyc, busy_cnt, overlap;
  logic rdy_at_done, first_rdy;
  logic [23:0] mreg = '0, stream, load_d, first_d;
  logic p_ld = 1'b0, p_sh = 1'b0;

  task automatic clr();
    cyc = 0; load_cnt = 0; load_cyc = -1; sv_first = -1; sv_last = -1; sv_cnt = 0;
    sh_cnt = 0; sh_first = -1; sh_last = -1; done_cnt = 0; done_cyc = -1;
    first_done_cyc = -1; busy_cnt = 0; overlap = 0; rdy_at_done = 1'b0;
    first_rdy = 1'b0; stream = '0; load_d = '0; first_d = '0;
  endtask

  // Shift register model: Load/Shift_En seen in the previous cycle take effect at the edge
  always @(negedge Clk) begin
    if (p_ld) mreg = m_d;
    else if (p_sh) mreg = {mreg[22:0], 1'b0};
    p_ld = m_ld;
    p_sh = m_sh;
    cyc++;
    if (m_ld) begin load_cnt++; load_cyc = cyc; load_d = m_d; end
    if (m_sv) begin
      if (sv_cnt == 0) sv_first = cyc;
      sv_last = cyc;
      sv_cnt++;
      if (sh_cnt < 24) stream[23 - sh_cnt] = mreg[23];
    end
    if (m_sh) begin
      if (sh_cnt == 0) sh_first = cyc;
      sh_last = cyc;
      sh_cnt++;
    end
    if (m_ld && m_sh) overlap++;
    if (m_dn) begin
      if (done_cnt == 0) begin first_done_cyc = cyc; first_rdy = m_rdy; first_d = m_d; end
      done_cnt++; done_cyc = cyc; rdy_at_done = m_rdy;
    end
    if (m_bz) busy_cnt++;
  end

  // Accept at the next edge (edge 0); cycle n is the period after edge n-1
  task automatic run_frame(input logic s, input logic [23:0] w, input int sv_last_e,
                           input int sh_first_e, input int sh_last_e, input int done_e,
                           input string tag);
    sel = s;
    if (s) begin v1 = 1'b1; d1 = w; end
    else   begin v0 = 1'b1; d0 = w; end
    @(posedge Clk); #1;
    clr();
    v0 = 1'b0; v1 = 1'b0;
    repeat (done_e + 1) @(posedge Clk);
    #1;
    chk({tag, "_load_cnt"}, load_cnt, 1);
    chk({tag, "_load_cyc"}, load_cyc, 1);
    chk({tag, "_sv_first"}, sv_first, 2);
    chk({tag, "_sv_last"}, sv_last, sv_last_e);
    chk({tag, "_sv_cnt"}, sv_cnt, sv_last_e - 1);
    chk({tag, "_sh_cnt"}, sh_cnt, 23);
    chk({tag, "_sh_first"}, sh_first, sh_first_e);
    chk({tag, "_sh_last"}, sh_last, sh_last_e);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, done_e);
    chk({tag, "_rdy_done"}, rdy_at_done, 1);
    chk({tag, "_stream"}, stream, w);
    chk({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    v0 = 1'b0; ab0 = 1'b0; d0 = '0;
    v1 = 1'b0; ab1 = 1'b0; d1 = '0;
    clr();
    #1;
    chk("rst_outs0", {ld0, sh0, sv0, bz0, dn0}, 5'b0);
    chk("rst_regd0", rd0, 24'h0);
    chk("rst_outs1", {ld1, sh1, sv1, bz1, dn1}, 5'b0);

    // idle after reset
    #11 Reset = 1'b0;
    @(posedge Clk); #1;
    clr();
    chk("idle_rdy", rdy0, 1);
    repeat (50) @(posedge Clk);
    #1;
    chk("idle_busy", busy_cnt, 0);
    chk("idle_load", load_cnt, 0);
    chk("idle_done", done_cnt, 0);

    run_frame(1'b0, 24'hA5C3F0, 97, 5, 93, 100, "f0");
    run_frame(1'b1, 24'h5A3C0F, 25, 2, 24, 26, "f1");

    // back-to-back with In_Valid held high
    sel = 1'b0;
    v0 = 1'b1; d0 = 24'hFFFFFF;
    @(posedge Clk); #1;
    clr();
    d0 = 24'h000001;
    repeat (100) @(posedge Clk);
    #1;
    v0 = 1'b0;
    repeat (100) @(posedge Clk);
    #1;
    chk("b2b_done1_cyc", first_done_cyc, 100);
    chk("b2b_done1_rdy", first_rdy, 1);
    chk("b2b_done1_regd", first_d, 24'hFFFFFF);
    chk("b2b_load_cnt", load_cnt, 2);
    chk("b2b_load2_cyc", load_cyc, 101);
    chk("b2b_load2_d", load_d, 24'h000001);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_done2_cyc", done_cyc, 200);
    chk("b2b_sh_cnt", sh_cnt, 46);

    // abort during bit index 10 (cycles 42..45), asserted in cycle 43
    v0 = 1'b1; d0 = 24'hC0FFEE;
    @(posedge Clk); #1;
    clr();
    v0 = 1'b0;
    repeat (42) @(posedge Clk);
    #1 ab0 = 1'b1;
    @(posedge Clk); #1;
    ab0 = 1'b0;
    chk("ab_busy", bz0, 0);
    chk("ab_sv", sv0, 0);
    repeat (80) @(posedge Clk);
    #1;
    chk("ab_done_cnt", done_cnt, 0);
    chk("ab_sh_cnt", sh_cnt, 10);
    v0 = 1'b1; ab0 = 1'b1; d0 = 24'h123456;
    #1 chk("ab_idle_rdy", rdy0, 0);
    clr();
    repeat (3) @(posedge Clk);
    #1;
    chk("ab_idle_noacc", load_cnt, 0);
    chk("ab_idle_busy", bz0, 0);
    ab0 = 1'b0;
    @(posedge Clk); #1;
    chk("ab_accept", ld0, 1);
    chk("ab_accept_d", rd0, 24'h123456);
    v0 = 1'b0;
    repeat (110) @(posedge Clk);
    #1;

    // asynchronous reset mid-SHIFT
    v0 = 1'b1; d0 = 24'h0F1E2D;
    @(posedge Clk); #1;
    clr();
    v0 = 1'b0;
    repeat (20) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    chk("arst_outs", {ld0, sh0, sv0, bz0, dn0}, 5'b0);
    chk("arst_regd", rd0, 24'h0);
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    chk("arst_rdy", rdy0, 1);
    chk("arst_busy", bz0, 0);
    repeat (100) @(posedge Clk);
    #1;
    chk("arst_nodone", done_cnt, 0);
    run_frame(1'b0, 24'h3CA596, 97, 5, 93, 100, "f2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift24_tx_ctrl.md
SHIFT24_TX_CTRL -- requirements
Module: shift24_tx_ctrl

Interface
REQ-001 Parameter BIT_CYCLES, default 4: clock cycles each serial bit is held; the module SHALL support values >= 1.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted after the last bit; the module SHALL support values >= 0.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port In_Valid, input, 1 bit: upstream offers In_Data.
REQ-006 The module SHALL have port In_Data, input, 24 bits: word to transmit, MSB first.
REQ-007 The module SHALL have port In_Ready, output, 1 bit: block can accept a word.
REQ-008 The module SHALL have port Abort, input, 1 bit: synchronous cancel of the frame in progress.
REQ-009 The module SHALL have port Reg_Load, output, 1 bit: drives the 24-bit shift register Load input.
REQ-010 The module SHALL have port Reg_D, output, 24 bits: drives the shift register D input.
REQ-011 The module SHALL have port Reg_Shift_En, output, 1 bit: drives the shift register Shift_En input.
REQ-012 The module SHALL have port Ser_Valid, output, 1 bit: shift register Shift_Out is a valid frame bit this cycle.
REQ-013 The module SHALL have port Busy, output, 1 bit: a frame is in progress (state not IDLE).
REQ-014 The module SHALL have port Done, output, 1 bit: one-cycle pulse on normal frame completion.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-016 In_Ready SHALL equal (state==IDLE) AND NOT Abort; it is the only combinational output.
REQ-017 A word SHALL be accepted at a rising edge where In_Valid and In_Ready are both 1; In_Data is captured into Reg_D and the state becomes LOAD.
REQ-018 In LOAD, Reg_Load SHALL be 1 for exactly one cycle; the next state SHALL be SHIFT with bit index 0 and cycle count 0.
REQ-019 In SHIFT, Ser_Valid SHALL be 1 and each bit SHALL occupy exactly BIT_CYCLES cycles, for 24 bits and 24*BIT_CYCLES cycles in total.
REQ-020 Reg_Shift_En SHALL be 1 only in the last cycle of bit periods 0..22, giving exactly 23 pulses per frame and none in bit period 23.
REQ-021 At the end of bit period 23, the state SHALL become GAP, or go directly to IDLE with Done when GAP_CYCLES=0.
REQ-022 GAP SHALL last GAP_CYCLES cycles with Ser_Valid=0, then go to IDLE.
REQ-023 Done SHALL be 1 in exactly the first IDLE cycle after a normally completed frame.
REQ-024 Reg_Load and Reg_Shift_En SHALL never be 1 in the same cycle.
REQ-025 Reg_D SHALL hold the captured word unchanged until the next accept.
REQ-026 Abort SHALL take priority over In_Valid: in IDLE it blocks acceptance; in LOAD, SHIFT or GAP the next state SHALL be IDLE with Ser_Valid, Reg_Load, Reg_Shift_En and Done all 0.
REQ-027 Busy SHALL be 1 in LOAD, SHIFT and GAP, and 0 in IDLE.
REQ-028 Upstream may hold In_Valid high continuously; back-to-back frames are then separated only by the single IDLE accept cycle.
REQ-029 All outputs except In_Ready SHALL be registered; the internal cycle counter SHALL be at least clog2(BIT_CYCLES) bits wide and the bit index 5 bits wide.

Reset
REQ-030 While Reset=1, the state SHALL be IDLE immediately (asynchronous), and Reg_D=24'h0, with Reg_Load, Reg_Shift_En, Ser_Valid, Busy and Done all 0.
REQ-031 On Reset assertion mid-frame, the frame SHALL be dropped, no Done pulse is produced, and In_Ready SHALL be 1 in the first cycle after release when Abort=0.
REQ-032 Deassertion of Reset SHALL take effect at the next rising edge, and no word SHALL be accepted while Reset=1.

Verification
REQ-033 Default parameters, In_Data=24'hA5C3F0 accepted at edge 0 -> Reg_Load=1 in cycle 1; Ser_Valid=1 in cycles 2..97; 23 Reg_Shift_En pulses at cycles 5, 9, ..., 93; Done=1 and In_Ready=1 at cycle 100; the serial stream from the attached register equals A5C3F0 MSB first.
REQ-034 BIT_CYCLES=1, GAP_CYCLES=0 -> Reg_Shift_En=1 in cycles 2..24, Ser_Valid=1 in cycles 2..25, Done at cycle 26.
REQ-035 In_Valid held high with two words 24'hFFFFFF then 24'h000001 -> second accept occurs exactly in the Done cycle, and neither frame is lost or duplicated.
REQ-036 Abort=1 in the cycle at bit index 10 -> IDLE next cycle, no Done, remaining Reg_Shift_En pulses absent; with In_Valid=1 and Abort=1 in IDLE -> no accept.
REQ-037 Reset pulsed asynchronously between clock edges during SHIFT -> all outputs 0 immediately and Reg_D=0; normal accept works after release.
REQ-038 In_Valid=0 held for 50 cycles after reset -> Busy=0, Reg_Load=0 and Done=0 throughout.
